// File: rtl/vec_mul_issue_ctrl.sv
// Issue/return controller for the vector multiplier datapath: registers operands,
// tracks requests through the fixed datapath latency, and buffers results in a credit-protected FIFO.
module vec_mul_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_op_a,
  input  logic [DATA_W-1:0]   in_op_b,
  input  logic [1:0]          in_precision,
  output logic [DATA_W-1:0]   mul_op_a,
  output logic [DATA_W-1:0]   mul_op_b,
  output logic [1:0]          mul_precision,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_result,
  output logic [1:0]          out_precision,
  output logic                out_err,
  output logic                busy
);

  localparam int STAGES = MUL_LATENCY;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [1:0] prec;
    logic       err;
  } tag_t;

  typedef struct packed {
    logic [2*DATA_W-1:0] res;
    logic [1:0]          prec;
    logic                err;
  } ent_t;

  logic [STAGES:0] vld_pipe;
  tag_t [STAGES:0] tag_pipe;
  tag_t            tag_in;
  logic [CNT_W-1:0] cnt, fill;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  ent_t             mem [FIFO_DEPTH];
  ent_t             head;
  logic             accept, pop, push, full;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign push   = vld_pipe[STAGES];
  assign full   = (fill == CNT_W'(FIFO_DEPTH));
  assign tag_in = '{prec: in_precision, err: (in_precision == 2'b11)};

  // Credits cover in-flight plus buffered results, so the FIFO can never overflow.
  assign in_ready = rst && (cnt < CNT_W'(FIFO_DEPTH));
  assign busy     = (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_op_a      <= '0;
      mul_op_b      <= '0;
      mul_precision <= '0;
    end else if (accept) begin
      mul_op_a      <= in_op_a;
      mul_op_b      <= in_op_b;
      mul_precision <= in_precision;
    end
  end

  // Free-running valid/tag pipe aligned to the datapath stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      tag_pipe <= {tag_pipe[STAGES-1:0], tag_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible behind a non-zero fill.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{res: mul_result, prec: tag_pipe[STAGES].prec, err: tag_pipe[STAGES].err};
  end

  assign head          = mem[rd_ptr];
  assign out_valid     = (fill != '0);
  assign out_result    = out_valid ? head.res  : '0;
  assign out_precision = out_valid ? head.prec : '0;
  assign out_err       = out_valid && head.err;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_vec_mul_issue_ctrl.sv
// Randomized bench for vec_mul_issue_ctrl against a queue-based model of
// outstanding requests and a behavioural lane-multiplier stand-in.
module tb_vec_mul_issue_ctrl;
  localparam int DW = 32;
  localparam int L  = 1;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_op_a = '0, in_op_b = '0;
  logic [1:0]    in_precision = '0;
  logic [DW-1:0] mul_op_a, mul_op_b;
  logic [1:0]    mul_precision;
  logic [2*DW-1:0] mul_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*DW-1:0] out_result;
  logic [1:0]    out_precision;
  logic          out_err;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_mul_issue_ctrl #(.DATA_W(DW), .MUL_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_precision(in_precision),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_precision(mul_precision),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_precision(out_precision), .out_err(out_err), .busy(busy)
  );

  // Lane-wise products: 4x8b, 2x16b or 1x32b.
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic [1:0] p);
    logic [63:0] r = '0;
    case (p)
      2'b00:   for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(a[i*8 +: 8]) * 16'(b[i*8 +: 8]);
      2'b01:   for (int i = 0; i < 2; i++) r[i*32 +: 32] = 32'(a[i*16 +: 16]) * 32'(b[i*16 +: 16]);
      default: r = 64'(a) * 64'(b);
    endcase
    return r;
  endfunction

  // Datapath stand-in with exactly L register stages.
  logic [63:0] dp [L];
  always @(posedge clk) begin
    dp[0] <= prod(mul_op_a, mul_op_b, mul_precision);
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign mul_result = dp[L-1];

  // Model: list of accepted-but-unconsumed requests, each visible from edge accept+L+1.
  typedef struct {
    logic [63:0] res;
    logic [1:0]  prec;
    int          rdy;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  m_p = '0;

  function automatic bit m_ov();
    return (q.size() > 0) && (cyc >= q[0].rdy);
  endfunction

  function automatic logic [135:0] m_vec();
    bit ov = m_ov();
    return {rst && (q.size() < D), ov, q.size() != 0,
            ov ? q[0].res : 64'h0, ov ? q[0].prec : 2'b00, ov && (q[0].prec == 2'b11),
            m_a, m_b, m_p};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_a = '0; m_b = '0; m_p = '0;
    end else begin
      bit mpop, macc;
      mpop = out_ready && m_ov();
      macc = in_valid && (q.size() < D);
      cyc++;
      if (mpop) void'(q.pop_front());
      if (macc) begin
        q.push_back('{prod(in_op_a, in_op_b, in_precision), in_precision, cyc + L + 1});
        m_a = in_op_a; m_b = in_op_b; m_p = in_precision;
      end
    end
  end

  logic [135:0] obs;
  assign obs = {in_ready, out_valid, busy, out_result, out_precision, out_err, mul_op_a, mul_op_b, mul_precision};

  task automatic drive(input logic v, input logic [1:0] p, input logic ordy);
    in_valid = v; in_op_a = $urandom; in_op_b = $urandom; in_precision = p; out_ready = ordy;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", obs); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== m_vec() || in_ready !== 1'b1) begin fails++; $display("FAIL reset_release: got %h want %h", obs, m_vec()); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 2'b01, 1'b1);
      if (i == 0) begin in_op_a = 32'h0003_0002; in_op_b = 32'h0005_0004; end
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL single cyc%0d: got %h want %h", i, obs, m_vec()); end
      if (i == 1) begin
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL single_early: out_valid %b want 0", out_valid); end
      end
      if (i == 2) begin
        tests++;
        if ({out_valid, out_result, out_precision, out_err} !== {1'b1, 64'h0000_000F_0000_0008, 2'b01, 1'b0}) begin
          fails++; $display("FAIL single_result: got %b %h %b %b want 1 0000000f00000008 01 0", out_valid, out_result, out_precision, out_err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, seen = 0, acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i < 6, 2'($urandom_range(0, 2)), 1'b1);
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL b2b cyc%0d: got %h want %h", i, obs, m_vec()); end
      if (out_valid) begin seen++; if (first < 0) first = i; last = i; end
    end
    tests++;
    if (acc != 6 || seen != 6 || last - first != 5) begin
      fails++; $display("FAIL b2b_stream: acc %0d results %0d span %0d want 6 6 6", acc, seen, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      if (i == 6) out_ready = 1'b1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL bp cyc%0d: got %h want %h", i, obs, m_vec()); end
      if (i == 5) begin
        tests++;
        if (acc != 4 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full: acc %0d in_ready %b want 4 0", acc, in_ready); end
      end
    end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_credit_return: in_ready %b want 1", in_ready); end
    drive(1'b1, 2'b10, 1'b0);
    if (in_valid && in_ready) acc++;
    @(negedge clk);
    tests++;
    if (acc != 5 || in_ready !== 1'b0 || obs !== m_vec()) begin
      fails++; $display("FAIL bp_fifth: acc %0d got %h want %h", acc, obs, m_vec());
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL bp_drain cyc%0d: got %h want %h", i, obs, m_vec()); end
    end
  endtask

  task automatic test_simultaneous();
    int acc = 0, pops = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), i >= 4);
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) pops++;
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL simul cyc%0d: got %h want %h", i, obs, m_vec()); end
      if (i == 4) begin
        tests++;
        if (acc != 4 || pops != 1 || in_ready !== 1'b1) begin
          fails++; $display("FAIL simul_at_full: acc %0d pops %0d in_ready %b want 4 1 1", acc, pops, in_ready);
        end
      end
    end
    tests++;
    if (acc != 5 || pops != 2 || in_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL simul_at_three: acc %0d pops %0d rdy %b busy %b want 5 2 1 1", acc, pops, in_ready, busy);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL simul_drain cyc%0d: got %h want %h", i, obs, m_vec()); end
    end
  endtask

  task automatic test_reserved();
    logic [2:0] errs = '0;
    int n = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, (i == 1) ? 2'b11 : 2'b00, 1'b1);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL resv cyc%0d: got %h want %h", i, obs, m_vec()); end
      if (i == 1) begin
        tests++;
        if (mul_precision !== 2'b11) begin fails++; $display("FAIL resv_fwd: mul_precision %b want 11", mul_precision); end
      end
      if (out_valid) begin errs = {errs[1:0], out_err}; n++; end
    end
    tests++;
    if (n != 3 || errs !== 3'b010) begin fails++; $display("FAIL resv_err: n %0d errs %b want 3 010", n, errs); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin fails++; $display("FAIL midrst_low: rdy/ov/busy %b want 000", {in_ready, out_valid, busy}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin fails++; $display("FAIL midrst_release: rdy/ov/busy %b want 100", {in_ready, out_valid, busy}); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      @(negedge clk);
      tests++;
      if (obs !== m_vec() || out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale cyc%0d: got %h want %h", i, obs, m_vec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL random cyc%0d: got %h want %h", i, obs, m_vec()); end
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin fails++; $display("FAIL random_drain cyc%0d: got %h want %h", i, obs, m_vec()); end
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL random_idle: busy %b ov %b want 0 0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reserved();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_mul_issue_ctrl.md
Name: vec_mul_issue_ctrl

Overview:
Issue/return controller placed around the vector multiplier datapath built from the 16-bit Urdhva-Tiryakbhyam multiplier units. It accepts operand-pair requests on a valid/ready interface and registers operands and precision onto the datapath inputs. It tracks each request through the fixed datapath latency with a valid/tag shift pipe. Results are captured into a credit-protected result FIFO, so downstream backpressure never drops a product.

Parameters:
DATA_W, 32, operand width per vector operand; product width is 2*DATA_W.
MUL_LATENCY, 1, clock edges from mul_op_* update to valid mul_result; must be at least 1.
FIFO_DEPTH, 4, result FIFO entries and maximum outstanding requests; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_op_a  in  DATA_W  operand A
in_op_b  in  DATA_W  operand B
in_precision  in  2  00=8-bit lanes, 01=16-bit lanes, 10=32-bit, 11=reserved
mul_op_a  out  DATA_W  registered operand A to datapath
mul_op_b  out  DATA_W  registered operand B to datapath
mul_precision  out  2  registered precision to datapath
mul_result  in  2*DATA_W  datapath product
out_valid  out  1  result FIFO non-empty
out_ready  in  1  result consumed when out_valid && out_ready
out_result  out  2*DATA_W  FIFO head product
out_precision  out  2  precision tag of head entry
out_err  out  1  head request used reserved precision 11
busy  out  1  any request in flight or buffered

Behaviour:
- Reset (rst low, async): mul_op_a/b=0, mul_precision=0, valid pipe cleared, FIFO empty, credit count=0. Outputs: out_valid=0, out_result=0, out_precision=0, out_err=0, busy=0, in_ready=0 while rst is low.
- Reset mid-operation discards all in-flight and buffered results. Datapath outputs arriving after reset release are ignored because the pipe is cleared.
- Credit counter cnt (0..FIFO_DEPTH) = requests accepted and not yet consumed at the output.
  - in_ready = (cnt < FIFO_DEPTH), decoded from registered cnt.
  - Accept: cnt+1. Output handshake: cnt-1. Both in the same cycle: cnt unchanged.
- Accept at edge k: mul_op_a/b and mul_precision load at edge k. A pipe entry {valid=1, prec, err=(prec==11)} enters stage 0.
- No accept: mul_op_* hold their last value. Stage 0 loads valid=0.
- The pipe shifts every cycle, unconditionally. Its tail is reached MUL_LATENCY edges after the stage-0 load.
  - When the tail is valid, the FIFO is written at the next edge with {mul_result, prec, err}.
  - The credit scheme guarantees the FIFO is never full on a write. A write to a full FIFO is a design error; add an assertion.
- Latency: out_valid rises MUL_LATENCY+1 edges after the accept edge if the FIFO is empty (2 cycles at the default).
- Throughput: one request per cycle sustained while out_ready=1.
- FIFO behaviour:
  - Register array, first-word fall-through: out_* show the head whenever out_valid=1, and are 0 when empty.
  - A write and a read in the same cycle are both honoured; an empty FIFO cannot be read.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Ordering: results return strictly in acceptance order.
- Reserved precision 11: the request is accepted and forwarded unchanged to mul_precision. The result is returned with out_err=1; there is no other special handling.
- busy = (cnt != 0).
- Datapath contract: the datapath is free-running with exactly MUL_LATENCY register stages. Its own reset output of 0 is never captured, because no valid tail occurs before the first accept.

Test Plan:
- Single request: a=0x0003_0002, b=0x0005_0004, prec=01, out_ready=1 -> out_valid 2 cycles after accept, out_result=0x0000_000F_0000_0008, out_err=0.
- Back-to-back: 6 requests on consecutive cycles, out_ready=1 -> in_ready stays 1, six results in order, one per cycle, no bubbles.
- Backpressure: out_ready=0, issue requests -> exactly 4 accepted, then in_ready=0. Assert out_ready for one cycle -> one pop, in_ready=1 next cycle, the fifth request is accepted, order is preserved.
- Simultaneous accept and pop at cnt=4: in_ready was 0, so no accept; with cnt=3, an accept and a pop in the same cycle leave cnt=3 and FIFO contents consistent.
- Reserved precision: prec=11 -> mul_precision=11 and out_err=1 on its result. Neighbouring prec=00 results have out_err=0.
- Reset mid-flight: 3 requests accepted, rst pulsed low for 1 cycle -> out_valid=0, busy=0, in_ready=1 after release. No stale result ever appears.
